// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor controller: register-file
// and instruction geometry, instruction field positions, opcode values and
// the time-step state encoding.
package proc_pkg;

  localparam int NUM_REGS = 8;
  localparam int IR_W     = 9;

  // Instruction fields: IR[8:6] opcode, IR[5:3] X, IR[2:0] Y
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_MV   = 3'b000;
  localparam opcode_t OP_MVI  = 3'b001;
  localparam opcode_t OP_ADD  = 3'b010;
  localparam opcode_t OP_SUB  = 3'b011;
  localparam opcode_t OP_LD   = 3'b100;
  localparam opcode_t OP_ST   = 3'b101;
  localparam opcode_t OP_MVNZ = 3'b110;
  localparam opcode_t OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    S_T0 = 2'd0,
    S_T1 = 2'd1,
    S_T2 = 2'd2,
    S_T3 = 2'd3
  } state_t;

endpackage

// File: rtl/dec3to8.sv
// 3-bit binary to 8-bit one-hot decoder with enable.
// Ports:
//   i_en  in  1  enable; output is all zeros when low
//   i_w   in  3  binary register index
//   o_y   out 8  one-hot decode of i_w
module dec3to8 (
  input  logic       i_en,
  input  logic [2:0] i_w,
  output logic [7:0] o_y
);

  always_comb begin
    o_y = '0;
    if (i_en) begin
      o_y[i_w] = 1'b1;
    end
  end

endmodule

// File: rtl/proc_control.sv
// Multicycle control FSM for the 16-bit datapath. Sequences time steps T0..T3,
// loads the instruction register in T0 and drives register-file enables,
// bus-source selects, ALU/memory strobes and Done from the decoded IR.
//
// state | meaning
// ------+------------------------------------------------------------
// S_T0  | idle / fetch: IRin follows Run, Run=1 starts an instruction
// S_T1  | first execute step (all ops; single-step ops finish here)
// S_T2  | second step: add/sub operand B, ld memory wait, st write
// S_T3  | final step for add/sub/ld: write result into Rx
//
// Ports:
//   i_clock   in  1         system clock, rising edge
//   i_resetn  in  1         async active-low reset; forces all outputs low
//   i_run     in  1         start next instruction (looked at in T0 only)
//   i_ir      in  IR_W      instruction register contents
//   i_g_zero  in  1         G register is zero (mvnz condition)
//   o_irin    out 1         instruction register load enable
//   o_rin     out NUM_REGS  one-hot register load enables
//   o_rout    out NUM_REGS  one-hot register-to-bus select
//   o_gout    out 1         G to bus
//   o_dinout  out 1         DIN to bus
//   o_ain     out 1         load A
//   o_gin     out 1         load G
//   o_addsub  out 1         0 = add, 1 = subtract
//   o_addrin  out 1         load address register
//   o_doutin  out 1         load data-out register
//   o_w_d     out 1         memory write strobe
//   o_done    out 1         high in the final step of each instruction
module proc_control
  import proc_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_resetn,
  input  logic                i_run,
  input  logic [IR_W-1:0]     i_ir,
  input  logic                i_g_zero,
  output logic                o_irin,
  output logic [NUM_REGS-1:0] o_rin,
  output logic [NUM_REGS-1:0] o_rout,
  output logic                o_gout,
  output logic                o_dinout,
  output logic                o_ain,
  output logic                o_gin,
  output logic                o_addsub,
  output logic                o_addrin,
  output logic                o_doutin,
  output logic                o_w_d,
  output logic                o_done
);

  state_t              r_state;
  state_t              w_next;
  opcode_t             w_op;
  logic [NUM_REGS-1:0] w_x_oh;
  logic [NUM_REGS-1:0] w_y_oh;

  assign w_op = i_ir[OP_MSB:OP_LSB];

  // Decoders are gated by reset so register selects fall to zero with it.
  dec3to8 u_dec_x (
    .i_en (i_resetn),
    .i_w  (i_ir[X_MSB:X_LSB]),
    .o_y  (w_x_oh)
  );

  dec3to8 u_dec_y (
    .i_en (i_resetn),
    .i_w  (i_ir[Y_MSB:Y_LSB]),
    .o_y  (w_y_oh)
  );

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_T0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    o_irin   = 1'b0;
    o_rin    = '0;
    o_rout   = '0;
    o_gout   = 1'b0;
    o_dinout = 1'b0;
    o_ain    = 1'b0;
    o_gin    = 1'b0;
    o_addsub = 1'b0;
    o_addrin = 1'b0;
    o_doutin = 1'b0;
    o_w_d    = 1'b0;
    o_done   = 1'b0;

    // While reset is held every output stays at its default of zero.
    if (i_resetn) begin
      case (r_state)
        S_T0: begin
          o_irin = i_run;
          if (i_run) begin
            w_next = S_T1;
          end
        end

        S_T1: begin
          w_next = S_T0;
          case (w_op)
            OP_MV: begin
              o_rout = w_y_oh;
              o_rin  = w_x_oh;
              o_done = 1'b1;
            end
            OP_MVI: begin
              o_dinout = 1'b1;
              o_rin    = w_x_oh;
              o_done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              o_rout = w_x_oh;
              o_ain  = 1'b1;
              w_next = S_T2;
            end
            OP_LD, OP_ST: begin
              o_rout   = w_y_oh;
              o_addrin = 1'b1;
              w_next   = S_T2;
            end
            OP_MVNZ: begin
              // Done still pulses when the move is suppressed.
              if (!i_g_zero) begin
                o_rout = w_y_oh;
                o_rin  = w_x_oh;
              end
              o_done = 1'b1;
            end
            default: begin
              o_done = 1'b1;
            end
          endcase
        end

        S_T2: begin
          w_next = S_T0;
          case (w_op)
            OP_ADD, OP_SUB: begin
              o_rout   = w_y_oh;
              o_gin    = 1'b1;
              o_addsub = (w_op == OP_SUB);
              w_next   = S_T3;
            end
            OP_LD: begin
              w_next = S_T3;
            end
            OP_ST: begin
              o_rout   = w_x_oh;
              o_doutin = 1'b1;
              o_w_d    = 1'b1;
              o_done   = 1'b1;
            end
            default: begin
              w_next = S_T0;
            end
          endcase
        end

        S_T3: begin
          w_next = S_T0;
          case (w_op)
            OP_ADD, OP_SUB: begin
              o_gout = 1'b1;
              o_rin  = w_x_oh;
              o_done = 1'b1;
            end
            OP_LD: begin
              o_dinout = 1'b1;
              o_rin    = w_x_oh;
              o_done   = 1'b1;
            end
            default: begin
              w_next = S_T0;
            end
          endcase
        end

        default: begin
          w_next = S_T0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_control.sv
module tb_proc_control;

  // Expected/actual output vector: {irin, rin[7:0], rout[7:0], flags[8:0]}
  localparam logic [8:0] F_NONE   = 9'h000;
  localparam logic [8:0] F_GOUT   = 9'h100;
  localparam logic [8:0] F_DINOUT = 9'h080;
  localparam logic [8:0] F_AIN    = 9'h040;
  localparam logic [8:0] F_GIN    = 9'h020;
  localparam logic [8:0] F_ADDSUB = 9'h010;
  localparam logic [8:0] F_ADDRIN = 9'h008;
  localparam logic [8:0] F_DOUTIN = 9'h004;
  localparam logic [8:0] F_WD     = 9'h002;
  localparam logic [8:0] F_DONE   = 9'h001;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic [8:0] flags;
  } exp_t;

  logic       clk;
  logic       resetn;
  logic       run;
  logic [8:0] ir;
  logic       g_zero;
  logic       irin;
  logic [7:0] rin;
  logic [7:0] rout;
  logic       gout, dinout, ain, gin, addsub, addrin, doutin, w_d, done;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   n_done;

  proc_control dut (
    .i_clock  (clk),
    .i_resetn (resetn),
    .i_run    (run),
    .i_ir     (ir),
    .i_g_zero (g_zero),
    .o_irin   (irin),
    .o_rin    (rin),
    .o_rout   (rout),
    .o_gout   (gout),
    .o_dinout (dinout),
    .o_ain    (ain),
    .o_gin    (gin),
    .o_addsub (addsub),
    .o_addrin (addrin),
    .o_doutin (doutin),
    .o_w_d    (w_d),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic i, input logic [7:0] ri,
                              input logic [7:0] ro, input logic [8:0] f);
    exp_t e;
    e.irin  = i;
    e.rin   = ri;
    e.rout  = ro;
    e.flags = f;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.irin  = irin;
    a.rin   = rin;
    a.rout  = rout;
    a.flags = {gout, dinout, ain, gin, addsub, addrin, doutin, w_d, done};
    return a;
  endfunction

  // Monitor: every falling edge pop the expected vector for this cycle and
  // compare, then check bus/one-hot invariants.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    int   n_src;
    a = actual();
    if (done) n_done++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got irin=%0b rin=%h rout=%h flags=%h, expected irin=%0b rin=%h rout=%h flags=%h",
                 $time, a.irin, a.rin, a.rout, a.flags, e.irin, e.rin, e.rout, e.flags);
      end
    end
    n_src = int'(rout != 8'h00) + int'(gout) + int'(dinout);
    n_checks++;
    if (n_src > 1) begin
      n_fail++;
      $display("FAIL bus_exclusive @%0t: got %0d sources, expected at most 1", $time, n_src);
    end
    n_checks++;
    if (!$onehot0(rin) || !$onehot0(rout)) begin
      n_fail++;
      $display("FAIL onehot @%0t: got rin=%h rout=%h, expected zero- or one-hot", $time, rin, rout);
    end
    n_checks++;
    if (rin != 8'h00 && n_src == 0) begin
      n_fail++;
      $display("FAIL rin_source @%0t: got rin=%h with no bus source, expected a source", $time, rin);
    end
  end

  // One clock cycle of stimulus: drive inputs just after the rising edge and
  // queue the outputs expected for the rest of that cycle.
  task automatic step(input logic r, input logic [8:0] instr, input logic gz, input exp_t e);
    run    = r;
    ir     = instr;
    g_zero = gz;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [8:0] I_ADD23  = 9'b010_010_011;
  localparam logic [8:0] I_MVI5   = 9'b001_101_000;
  localparam logic [8:0] I_SUB12  = 9'b011_001_010;
  localparam logic [8:0] I_MVNZ07 = 9'b110_000_111;
  localparam logic [8:0] I_ST46   = 9'b101_100_110;
  localparam logic [8:0] I_LD23   = 9'b100_010_011;
  localparam logic [8:0] I_MV33   = 9'b000_011_011;
  localparam logic [8:0] I_ADD22  = 9'b010_010_010;
  localparam logic [8:0] I_NOP    = 9'b111_000_000;

  initial begin
    exp_t z;
    n_checks = 0;
    n_fail   = 0;
    n_done   = 0;
    z        = mk(1'b0, 8'h00, 8'h00, F_NONE);
    resetn   = 1'b0;
    run      = 1'b1;
    ir       = I_ADD23;
    g_zero   = 1'b0;
    @(posedge clk);
    #1;

    // Reset held: outputs zero even with Run high
    step(1'b1, I_ADD23, 1'b0, z);
    resetn = 1'b1;

    // add R2,R3 aborted by reset in T2
    step(1'b1, I_ADD23, 1'b0, mk(1'b1, 8'h00, 8'h00, F_NONE));
    step(1'b0, I_ADD23, 1'b0, mk(1'b0, 8'h00, 8'h04, F_AIN));
    resetn = 1'b0;
    step(1'b0, I_ADD23, 1'b0, z);
    resetn = 1'b1;
    step(1'b0, I_ADD23, 1'b0, z);
    step(1'b0, I_ADD23, 1'b0, z);

    // mvi R5: IRin following Run proves the FSM is back in T0
    step(1'b1, I_MVI5, 1'b0, mk(1'b1, 8'h00, 8'h00, F_NONE));
    step(1'b0, I_MVI5, 1'b0, mk(1'b0, 8'h20, 8'h00, F_DINOUT | F_DONE));
    step(1'b0, I_MVI5, 1'b0, z);

    // sub R1,R2
    step(1'b1, I_SUB12, 1'b0, mk(1'b1, 8'h00, 8'h00, F_NONE));
    step(1'b0, I_SUB12, 1'b0, mk(1'b0, 8'h00, 8'h02, F_AIN));
    step(1'b0, I_SUB12, 1'b0, mk(1'b0, 8'h00, 8'h04, F_GIN | F_ADDSUB));
    step(1'b0, I_SUB12, 1'b0, mk(1'b0, 8'h02, 8'h00, F_GOUT | F_DONE));
    step(1'b0, I_SUB12, 1'b0, z);

    // mvnz R0,R7 with G zero, then G non-zero
    step(1'b1, I_MVNZ07, 1'b1, mk(1'b1, 8'h00, 8'h00, F_NONE));
    step(1'b0, I_MVNZ07, 1'b1, mk(1'b0, 8'h00, 8'h00, F_DONE));
    step(1'b1, I_MVNZ07, 1'b0, mk(1'b1, 8'h00, 8'h00, F_NONE));
    step(1'b0, I_MVNZ07, 1'b0, mk(1'b0, 8'h01, 8'h80, F_DONE));

    // st R4,R6
    step(1'b1, I_ST46, 1'b0, mk(1'b1, 8'h00, 8'h00, F_NONE));
    step(1'b0, I_ST46, 1'b0, mk(1'b0, 8'h00, 8'h40, F_ADDRIN));
    step(1'b0, I_ST46, 1'b0, mk(1'b0, 8'h00, 8'h10, F_DOUTIN | F_WD | F_DONE));

    // ld R2,R3 (Run high in T1..T3 must be ignored)
    step(1'b1, I_LD23, 1'b0, mk(1'b1, 8'h00, 8'h00, F_NONE));
    step(1'b1, I_LD23, 1'b0, mk(1'b0, 8'h00, 8'h08, F_ADDRIN));
    step(1'b1, I_LD23, 1'b0, z);
    step(1'b0, I_LD23, 1'b0, mk(1'b0, 8'h04, 8'h00, F_DINOUT | F_DONE));
    step(1'b0, I_LD23, 1'b0, z);

    // Run held high: mv R3,R3 ; add R2,R2 ; nop back to back
    step(1'b1, I_MV33,  1'b0, mk(1'b1, 8'h00, 8'h00, F_NONE));
    step(1'b1, I_MV33,  1'b0, mk(1'b0, 8'h08, 8'h08, F_DONE));
    step(1'b1, I_ADD22, 1'b0, mk(1'b1, 8'h00, 8'h00, F_NONE));
    step(1'b1, I_ADD22, 1'b0, mk(1'b0, 8'h00, 8'h04, F_AIN));
    step(1'b1, I_ADD22, 1'b0, mk(1'b0, 8'h00, 8'h04, F_GIN));
    step(1'b1, I_ADD22, 1'b0, mk(1'b0, 8'h04, 8'h00, F_GOUT | F_DONE));
    step(1'b1, I_NOP,   1'b0, mk(1'b1, 8'h00, 8'h00, F_NONE));
    step(1'b1, I_NOP,   1'b0, mk(1'b0, 8'h00, 8'h00, F_DONE));
    step(1'b0, I_NOP,   1'b0, z);
    step(1'b0, I_NOP,   1'b0, z);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    // mvi, sub, mvnz x2, st, ld, mv, add, nop; the aborted add gives none
    n_checks++;
    if (n_done != 9) begin
      n_fail++;
      $display("FAIL done_count: got %0d, expected 9", n_done);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
